// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hit path and one blocking miss at a time.
// Optional hit/miss statistics ports are built when ICACHE_STATS_EN is defined.
module icache #(
  parameter int XLEN         = 32,
  parameter int ICACHE_LINES = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] proc2Icache_addr,
  output logic [63:0]     Icache_data_out,
  output logic            Icache_valid_out,
  output logic [1:0]      proc2Imem_command,
  output logic [XLEN-1:0] proc2Imem_addr,
  input  logic [3:0]      Imem2proc_response,
  input  logic [63:0]     Imem2proc_data,
  input  logic [3:0]      Imem2proc_tag
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]     icache_hits,
  output logic [31:0]     icache_misses
`endif
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = XLEN - 3 - IDX_W;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                  state, state_nxt;
  logic [ICACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]        tag_arr  [ICACHE_LINES];
  logic [63:0]             data_arr [ICACHE_LINES];

  logic [IDX_W-1:0] idx, miss_idx;
  logic [TAG_W-1:0] addr_tag, miss_tag;
  logic [3:0]       mem_tag;
  logic             hit, start_miss, take_resp, fill;
  logic             addr_offset_unused;

  assign idx                = proc2Icache_addr[IDX_W+2:3];
  assign addr_tag           = proc2Icache_addr[XLEN-1:IDX_W+3];
  assign addr_offset_unused = ^proc2Icache_addr[2:0];

  // Lookup is purely combinational; a line filled this cycle is seen next cycle.
  assign hit              = !reset && line_valid[idx] && (tag_arr[idx] == addr_tag);
  assign Icache_valid_out = hit;
  assign Icache_data_out  = hit ? data_arr[idx] : 64'd0;

  always_comb begin
    state_nxt         = state;
    proc2Imem_command = BUS_NONE;
    proc2Imem_addr    = '0;
    start_miss        = 1'b0;
    take_resp         = 1'b0;
    fill              = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (!hit) begin
            start_miss = 1'b1;
            state_nxt  = REQ;
          end
        end
        REQ: begin
          proc2Imem_command = BUS_LOAD;
          proc2Imem_addr    = {miss_tag, miss_idx, 3'b000};
          if (Imem2proc_response != 4'd0) begin
            take_resp = 1'b1;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          // A zero captured tag never matches, so idle-bus tag 0 cannot fill.
          if ((Imem2proc_tag == mem_tag) && (mem_tag != 4'd0)) begin
            fill      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      line_valid <= '0;
      mem_tag    <= 4'd0;
    end else begin
      state <= state_nxt;
      if (take_resp) mem_tag <= Imem2proc_response;
      if (fill) begin
        line_valid[miss_idx] <= 1'b1;
        mem_tag              <= 4'd0;
      end
    end
  end

  // Miss address and line storage carry no reset; they are qualified by state and valid bits.
  always_ff @(posedge clock) begin
    if (start_miss) begin
      miss_idx <= idx;
      miss_tag <= addr_tag;
    end
    if (fill) begin
      tag_arr[miss_idx]  <= miss_tag;
      data_arr[miss_idx] <= Imem2proc_data;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      icache_hits   <= 32'd0;
      icache_misses <= 32'd0;
    end else begin
      if (hit)        icache_hits   <= icache_hits + 32'd1;
      if (start_miss) icache_misses <= icache_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes model predictions, a negedge monitor compares.
// Build with ICACHE_STATS_EN defined to also check the statistics counters.
module tb_icache;
  localparam int XLEN  = 32;
  localparam int LINES = 32;

  logic            clock = 1'b1;
  logic            reset;
  logic [XLEN-1:0] proc2Icache_addr;
  logic [63:0]     Icache_data_out;
  logic            Icache_valid_out;
  logic [1:0]      proc2Imem_command;
  logic [XLEN-1:0] proc2Imem_addr;
  logic [3:0]      Imem2proc_response;
  logic [63:0]     Imem2proc_data;
  logic [3:0]      Imem2proc_tag;
`ifdef ICACHE_STATS_EN
  logic [31:0]     icache_hits;
  logic [31:0]     icache_misses;
`endif

  icache #(.XLEN(XLEN), .ICACHE_LINES(LINES)) dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Icache_addr   (proc2Icache_addr),
    .Icache_data_out    (Icache_data_out),
    .Icache_valid_out   (Icache_valid_out),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag)
`ifdef ICACHE_STATS_EN
    ,
    .icache_hits        (icache_hits),
    .icache_misses      (icache_misses)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic [1:0]  cmd;
    logic [31:0] maddr;
    logic        chk_addr;
    logic [31:0] hits;
    logic [31:0] misses;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: cache contents keyed by block number, plus the single pending miss.
  bit          mv   [LINES];
  logic [28:0] mblk [LINES];
  logic [63:0] md   [LINES];
  int          phase = 0;      // 0 no miss, 1 requesting, 2 waiting for data
  logic [28:0] mblock = '0;
  logic [3:0]  mtag = '0;
  logic [31:0] mhits = '0, mmisses = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("valid_out", {63'd0, Icache_valid_out}, {63'd0, e.valid});
      check("data_out", Icache_data_out, e.data);
      check("command", {62'd0, proc2Imem_command}, {62'd0, e.cmd});
      if (e.chk_addr) check("imem_addr", {32'd0, proc2Imem_addr}, {32'd0, e.maddr});
`ifdef ICACHE_STATS_EN
      check("hits", {32'd0, icache_hits}, {32'd0, e.hits});
      check("misses", {32'd0, icache_misses}, {32'd0, e.misses});
`endif
    end
  end

  task automatic cycle(input logic rst, input logic [31:0] a, input logic [3:0] resp,
                       input logic [3:0] tg, input logic [63:0] d);
    logic [28:0] blk;
    int          li;
    bit          h;
    exp_t        e;
    reset              = rst;
    proc2Icache_addr   = a;
    Imem2proc_response = resp;
    Imem2proc_tag      = tg;
    Imem2proc_data     = d;
    blk = a[31:3];
    li  = int'(blk % LINES);
    h   = !rst && mv[li] && (mblk[li] == blk);
    e.valid    = h;
    e.data     = h ? md[li] : 64'd0;
    e.cmd      = (!rst && phase == 1) ? 2'd1 : 2'd0;
    e.maddr    = (e.cmd == 2'd1) ? {mblock, 3'b000} : 32'd0;
    e.chk_addr = rst || (e.cmd == 2'd1);
    e.hits     = mhits;
    e.misses   = mmisses;
    expq.push_back(e);
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < LINES; i++) mv[i] = 0;
      phase = 0; mtag = 0; mhits = 0; mmisses = 0;
    end else begin
      if (h) mhits++;
      if (phase == 0) begin
        if (!h) begin phase = 1; mblock = blk; mmisses++; end
      end else if (phase == 1) begin
        if (resp != 0) begin phase = 2; mtag = resp; end
      end else begin
        if (tg == mtag && mtag != 0) begin
          mv[int'(mblock % LINES)]   = 1;
          mblk[int'(mblock % LINES)] = mblock;
          md[int'(mblock % LINES)]   = d;
          phase = 0;
          mtag  = 0;
        end
      end
    end
    #1;
  endtask

  initial begin
    // Reset, then first miss and fill of 0x100
    cycle(1, 32'h100, 0, 0, 0);
    cycle(1, 32'h100, 0, 0, 0);
    cycle(0, 32'h100, 0, 0, 0);
    cycle(0, 32'h100, 3, 0, 0);
    cycle(0, 32'h100, 0, 3, 64'hDEADBEEF_00000013);
    cycle(0, 32'h104, 0, 0, 0);
    // Rejected requests are reissued unchanged
    cycle(0, 32'h300, 0, 0, 0);
    repeat (4) cycle(0, 32'h300, 0, 0, 0);
    cycle(0, 32'h300, 5, 0, 0);
    cycle(0, 32'h300, 0, 9, 64'h1111);
    cycle(0, 32'h300, 0, 5, 64'h3333_0000_0000_0300);
    cycle(0, 32'h300, 0, 0, 0);
    // Hit under miss with a fetch redirect
    cycle(0, 32'h108, 0, 0, 0);
    cycle(0, 32'h108, 2, 0, 0);
    cycle(0, 32'h108, 0, 2, 64'h0108_0108_0108_0108);
    cycle(0, 32'h200, 0, 0, 0);
    cycle(0, 32'h200, 4, 0, 0);
    cycle(0, 32'h108, 0, 0, 0);
    cycle(0, 32'h108, 0, 4, 64'h0200_0200_0200_0200);
    cycle(0, 32'h204, 0, 0, 0);
    cycle(0, 32'h108, 0, 0, 0);
    // Conflict eviction
    cycle(0, 32'h000, 0, 0, 0);
    cycle(0, 32'h000, 6, 0, 0);
    cycle(0, 32'h000, 0, 6, 64'hAAAA);
    cycle(0, 32'h000, 0, 0, 0);
    cycle(0, 32'h100, 0, 0, 0);
    cycle(0, 32'h100, 8, 0, 0);
    cycle(0, 32'h100, 0, 8, 64'hBBBB);
    cycle(0, 32'h100, 0, 0, 0);
    cycle(0, 32'h000, 0, 0, 0);
    cycle(0, 32'h000, 1, 0, 0);
    cycle(0, 32'h000, 0, 1, 64'hCCCC);
    // Reset mid-wait; the stale tag must be ignored
    cycle(0, 32'h400, 0, 0, 0);
    cycle(0, 32'h400, 7, 0, 0);
    cycle(0, 32'h400, 0, 0, 0);
    cycle(1, 32'h400, 0, 0, 0);
    cycle(1, 32'h400, 0, 0, 0);
    cycle(0, 32'h400, 0, 7, 64'hBAD);
    cycle(0, 32'h400, 0, 7, 64'hBAD);
    cycle(0, 32'h400, 1, 0, 0);
    cycle(0, 32'h400, 0, 1, 64'h4444);
    cycle(0, 32'h400, 0, 0, 0);
    // Randomized traffic with occasional resets and noise tags
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      logic [3:0]  r, t;
      logic        rs;
      a = (32'($urandom_range(0, 127)) << 3) | ($urandom & 32'h7);
      if ($urandom % 8 == 0) a = a | 32'h8000_0000;
      r  = ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      t  = ($urandom % 4 == 0) ? mtag : 4'($urandom % 16);
      rs = ($urandom % 200 == 0);
      cycle(rs, a, r, t, {$urandom, $urandom});
    end
    repeat (3) @(posedge clock);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 clock  input  1  system clock; every state element updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on the clock rising edge.
REQ-003 proc2Icache_addr  input  XLEN  fetch byte address from the fetch stage; bits [2:0] are ignored.
REQ-004 Icache_data_out  output  64  8-byte block holding the fetched instruction pair.
REQ-005 Icache_valid_out  output  1  Icache_data_out is valid for proc2Icache_addr this cycle.
REQ-006 proc2Imem_command  output  2  bus command: BUS_NONE=0, BUS_LOAD=1; BUS_STORE is never issued.
REQ-007 proc2Imem_addr  output  XLEN  block-aligned miss address, with bits [2:0] equal to 0.
REQ-008 Imem2proc_response  input  4  nonzero value = request accepted, with this value as its transaction tag; 0 = request rejected.
REQ-009 Imem2proc_data  input  64  returned block; valid in the cycle its tag appears.
REQ-010 Imem2proc_tag  input  4  tag of the data returned this cycle; 0 = no data.
REQ-011 Parameter ICACHE_LINES, default 32, number of direct-mapped lines, power of two.

Function
REQ-012 Address split: offset [2:0]; index [2+log2(ICACHE_LINES):3]; tag = all remaining upper bits.
REQ-013 Storage per line: valid bit, tag, 64-bit data.
REQ-014 Hit = valid[index] && stored tag == address tag; hit is combinational, with zero-cycle latency; Icache_data_out = line data.
REQ-015 Icache_data_out is 0 when Icache_valid_out is 0.
REQ-016 The block has three states, IDLE, REQ and WAIT.
REQ-017 IDLE: on a miss, latch the block address and index, then go to REQ in the next cycle.
REQ-018 REQ: drive BUS_LOAD with the latched address.
  - Imem2proc_response != 0: capture the tag and go to WAIT.
  - Imem2proc_response == 0: stay in REQ and reissue the request next cycle.
REQ-019 WAIT: drive BUS_NONE.
  - When Imem2proc_tag == captured tag and the captured tag != 0: write the line from Imem2proc_data, set valid, and go to IDLE.
REQ-020 A fill writes the latched index and tag, not the current proc2Icache_addr.
  - The fill therefore completes even when fetch redirects mid-miss.
  - A redirected miss starts only after the block returns to IDLE.
REQ-021 The line written in a cycle becomes visible as a hit starting the next cycle; there is no same-cycle bypass.
REQ-022 Returned tags that do not match the captured tag are ignored in every state.
REQ-023 proc2Imem_command is BUS_NONE in IDLE and in WAIT.
REQ-024 At most one outstanding miss; no new request is issued outside REQ.
REQ-025 A hit during REQ or WAIT is still served (hit under miss).

Reset
REQ-026 Reset clears all valid bits and sets the state to IDLE; captured tag = 0.
REQ-027 Output values while reset is high:
  - proc2Imem_command = BUS_NONE.
  - proc2Imem_addr = 0.
  - Icache_valid_out = 0.
  - Icache_data_out = 0.
REQ-028 Reset asserted mid-miss abandons the transaction; the late data tag is ignored by REQ-022.
REQ-029 Tag and data arrays need not be cleared by reset.

Configuration
REQ-030 Macro ICACHE_STATS_EN controls optional statistics output.
  - When defined, outputs icache_hits[31:0] and icache_misses[31:0] are present.
  - icache_hits increments on each cycle with a hit.
  - icache_misses increments on each IDLE->REQ transition.
  - Both counters reset to 0 and wrap at 2^32.
REQ-031 Without ICACHE_STATS_EN, those ports and counters do not exist; all other behaviour is identical.

Verification
REQ-032 Post-reset, addr=0x100 -> valid_out=0; next cycle command=BUS_LOAD with addr=0x100; response=3 -> WAIT; tag=3 with data=0xDEADBEEF_00000013 -> one cycle later, valid_out=1 with that data.
REQ-033 Response=0 for 4 cycles, then 5 -> BUS_LOAD held with addr unchanged for 5 cycles, then BUS_NONE.
REQ-034 Miss at 0x200 (index 0); fetch redirects to a cached line at 0x108 during WAIT -> 0x108 hits immediately; fill lands at index 0; a following 0x204 hits.
REQ-035 Conflict: 0x000 filled, then 0x100 (same index, different tag) -> miss; after the fill, 0x000 misses again.
REQ-036 Reset mid-WAIT with tag 7 outstanding; tag 7 returns after reset -> no line valid; a new miss is issued normally.
REQ-037 With ICACHE_STATS_EN: 3 misses followed by 10 hit cycles -> icache_misses=3 and icache_hits=10.
